// File: rtl/reg_dump.sv
// reg_dump: serialises the eight registers of a register file, one
// UART-style frame per register (start, 8 data bits LSB first, stop).
module reg_dump #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clka,
  input  logic       reset_in,
  input  logic       start_in,
  input  logic [7:0] rd_data_in,
  output logic [2:0] sr_addr_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int CW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic [2:0]    addr;
  logic [2:0]    addr_n;
  logic          tx;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // State, counters, shift register and the tx flop.
  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      addr  <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      addr  <= addr_n;
      tx    <= tx_n;
    end
  end

  // Next-state logic; tx_n is the line level of the coming cycle,
  // so it only moves when a bit period or a state ends.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    addr_n  = addr;
    tx_n    = tx;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        tx_n  = 1'b1;
        if (start_in) begin
          state_n = LOAD;
          addr_n  = '0;
        end
      end
      LOAD: begin
        shreg_n = rd_data_in;
        state_n = START;
        cnt_n   = '0;
        tx_n    = 1'b0;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shreg[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
            tx_n  = shreg[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (addr == 3'd7) begin
            state_n = DONE;
          end else begin
            addr_n  = addr + 1'b1;
            state_n = LOAD;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        addr_n  = '0;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign sr_addr_out = addr;
  assign tx_out      = tx;
  assign busy_out    = (state == LOAD) || (state == START) ||
                       (state == DATA) || (state == STOP);
  assign done_out    = (state == DONE);

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: randomised dumps of a modelled register file, with a
// frame-decoding monitor checked against an expected-response queue.
module tb_reg_dump;

  localparam int CPB = 4;
  localparam int F   = 1 + 10 * CPB;
  localparam int NS  = 10 * CPB;

  logic       clka = 1'b0;
  logic       reset_in;
  logic       start_in;
  logic [7:0] rd_data;
  logic [2:0] sr_addr;
  logic       tx_out;
  logic       busy_out;
  logic       done_out;

  logic [7:0] regs [8];

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q  [$];
  logic       done_q [$];

  int         wr_reg [$];
  int         wr_off [$];
  logic [7:0] wr_val [$];

  always #5 clka = ~clka;

  assign rd_data = regs[sr_addr];

  reg_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clka        (clka),
    .reset_in    (reset_in),
    .start_in    (start_in),
    .rd_data_in  (rd_data),
    .sr_addr_out (sr_addr),
    .tx_out      (tx_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  // Expected bytes: register k as it stands when frame k loads,
  // i.e. including every write issued up to offset k*F.
  task automatic push_exp(input int nfr, input bit full);
    logic [7:0] m [8];
    for (int k = 0; k < nfr; k++) begin
      for (int r = 0; r < 8; r++) m[r] = regs[r];
      for (int w = 0; w < wr_off.size(); w++)
        if (wr_off[w] <= k * F) m[wr_reg[w]] = wr_val[w];
      exp_q.push_back(m[k]);
    end
    if (full) done_q.push_back(1'b1);
  endtask

  task automatic issue(input bit hold);
    @(posedge clka); #1;
    start_in = 1'b1;
    @(posedge clka); #1;
    if (!hold) start_in = 1'b0;
  endtask

  // Runs from just after the accepting edge; applies scheduled
  // writes and an optional reset at a cycle offset.
  task automatic run_dump(input int rst_off);
    bit seen;
    seen = 1'b0;
    for (int o = 0; o <= 8 * F + 4; o++) begin
      for (int w = 0; w < wr_off.size(); w++)
        if (wr_off[w] == o) regs[wr_reg[w]] = wr_val[w];
      if (o == rst_off) begin
        reset_in = 1'b1;
        #1;
        chk("abort_tx", tx_out, 1);
        chk("abort_busy", busy_out, 0);
        chk("abort_done", done_out, 0);
        chk("abort_addr", sr_addr, 0);
        @(posedge clka);
        @(posedge clka); #1;
        reset_in = 1'b0;
        seen = 1'b1;
        break;
      end
      if (done_out) begin
        seen = 1'b1;
        break;
      end
      @(posedge clka); #1;
    end
    if (!seen) chk("dump_timeout", 0, 1);
    wr_reg.delete();
    wr_off.delete();
    wr_val.delete();
  endtask

  task automatic dump_once();
    push_exp(8, 1'b1);
    issue(1'b0);
    run_dump(-1);
    @(posedge clka); #1;
  endtask

  // Monitor: frame receiver and done checker.
  int         ncyc = 0;
  int         load_cyc = 0;
  logic       busy_prev = 1'b0;
  logic       tx_prev = 1'b1;
  bit         rx_active = 1'b0;
  int         rx_n = 0;
  logic       rx_s [NS];

  always @(negedge clka) begin
    logic [7:0] dec;
    logic [7:0] eb;
    logic [9:0] pat;
    int         errs;
    ncyc++;
    if (reset_in) begin
      rx_active = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (busy_out && !busy_prev) load_cyc = ncyc;
      busy_prev = busy_out;
      if (!rx_active && !tx_out && tx_prev) begin
        rx_active = 1'b1;
        rx_n = 0;
      end
      if (rx_active) begin
        rx_s[rx_n] = tx_out;
        rx_n++;
        if (rx_n == NS) begin
          rx_active = 1'b0;
          for (int i = 0; i < 8; i++)
            dec[i] = rx_s[(1 + i) * CPB + CPB / 2];
          if (exp_q.size() == 0) begin
            chk("frame_expected", 0, 1);
          end else begin
            eb = exp_q.pop_front();
            pat = {1'b1, eb, 1'b0};
            errs = 0;
            for (int i = 0; i < NS; i++)
              if (rx_s[i] !== pat[i / CPB]) errs++;
            chk("frame_byte", {24'd0, dec}, {24'd0, eb});
            chk("frame_timing", errs, 0);
          end
        end
      end
      if (done_out) begin
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) void'(done_q.pop_front());
        chk("done_gap", ncyc - load_cyc, 8 * F);
        chk("done_busy", busy_out, 0);
        chk("done_tx", tx_out, 1);
      end
    end
    tx_prev = tx_out;
  end

  initial begin
    reset_in = 1'b1;
    start_in = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    #3;
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_addr", sr_addr, 0);
    @(posedge clka);
    @(posedge clka); #1;
    reset_in = 1'b0;

    // Fixed pattern 0x11..0x88.
    for (int i = 0; i < 8; i++) regs[i] = 8'(8'h11 * (i + 1));
    dump_once();

    // 0xA5 in register 0, rest random.
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    regs[0] = 8'hA5;
    dump_once();

    // start held high throughout: one dump, then a fresh one
    // only at the first IDLE edge.
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    push_exp(8, 1'b1);
    issue(1'b1);
    run_dump(-1);
    push_exp(8, 1'b1);
    @(posedge clka); #1;
    chk("hold_idle_busy", busy_out, 0);
    chk("hold_idle_done", done_out, 0);
    @(posedge clka); #1;
    chk("hold_accept_busy", busy_out, 1);
    chk("hold_accept_addr", sr_addr, 0);
    start_in = 1'b0;
    run_dump(-1);
    @(posedge clka); #1;

    // Writes to register 3 during frames 2 and 3.
    for (int i = 0; i < 8; i++) regs[i] = 8'(8'h11 * (i + 1));
    wr_reg.push_back(3); wr_val.push_back(8'h99);
    wr_off.push_back(2 * F + 20);
    wr_reg.push_back(3); wr_val.push_back(8'h11);
    wr_off.push_back(3 * F + 20);
    dump_once();

    // Random contents.
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      dump_once();
    end

    // Reset during DATA of frame 5: five frames, no done.
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    push_exp(5, 1'b0);
    issue(1'b0);
    run_dump(5 * F + 1 + CPB + 6);
    repeat (5) @(posedge clka);
    #1;
    chk("post_rst_busy", busy_out, 0);
    chk("post_rst_addr", sr_addr, 0);
    chk("post_rst_tx", tx_out, 1);

    // Restart begins again at register 0.
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    dump_once();

    repeat (4) @(posedge clka);
    #1;
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clka cycles per serial bit; SHALL be at least 2.
REQ-002 clka  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset_in  input  1  reset, asynchronous and active-high.
REQ-004 start_in  input  1  dump request; SHALL be sampled only in IDLE.
REQ-005 rd_data_in  input  8  register read data returned combinationally for sr_addr_out (register file sr1 port).
REQ-006 sr_addr_out  output  3  register index driven to the register file sr1 select.
REQ-007 tx_out  output  1  registered serial line, high when idle.
REQ-008 busy_out  output  1  high from the start-acceptance cycle until the DONE cycle, exclusive.
REQ-009 done_out  output  1  single-cycle pulse on completion of the 8th frame.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, LOAD, START, DATA, STOP, DONE.
REQ-011 In IDLE, start_in=1 at a rising edge SHALL move the FSM to LOAD with sr_addr_out=0 and busy_out=1.
REQ-012 LOAD SHALL last one cycle; at its closing edge the FSM SHALL capture rd_data_in into an 8-bit shift register and go to START.
REQ-013 START SHALL hold tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-014 DATA SHALL drive tx_out from shift-register bit 0 (LSB first) for CLKS_PER_BIT cycles per bit.
- shift right after each bit
- go to STOP after bit 7
REQ-015 STOP SHALL hold tx_out=1 for CLKS_PER_BIT cycles.
- then: if sr_addr_out=7, go to DONE
- else increment sr_addr_out and go to LOAD
REQ-016 DONE SHALL last one cycle with done_out=1, busy_out=0 and tx_out=1, then return to IDLE with sr_addr_out=0.
REQ-017 A bit-period counter SHALL count 0..CLKS_PER_BIT-1 and clear on every bit boundary and state change; no bit period SHALL be lengthened or shortened.
REQ-018 Each frame SHALL occupy 1+10*CLKS_PER_BIT cycles.
- a full dump SHALL span 8*(1+10*CLKS_PER_BIT) cycles from LOAD entry to DONE entry
REQ-019 Register contents SHALL be sampled only at the LOAD closing edge.
- writes during a frame SHALL NOT alter that frame
- a later register's frame SHALL reflect writes made before its own LOAD
REQ-020 start_in asserted in any state other than IDLE, including DONE, SHALL be ignored and SHALL NOT be queued.
REQ-021 sr_addr_out SHALL remain stable from LOAD entry until the STOP exit of the same frame.
REQ-022 tx_out SHALL be glitch-free: a flop output that changes only at bit boundaries.

Reset
REQ-023 While reset_in=1, independent of clka, the block SHALL hold: state=IDLE, tx_out=1, busy_out=0, done_out=0, sr_addr_out=0, shift register=0, counters=0.
REQ-024 A reset asserted mid-frame SHALL abort the dump immediately and SHALL produce no done_out pulse; a new start_in SHALL be required after release.
REQ-025 After reset release, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-026 Full dump, CLKS_PER_BIT=4, registers 0..7 = 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88:
- stimulus: 1-cycle start_in pulse
- response: eight frames, each 0 + LSB-first data + 1, each bit exactly 4 cycles
- done_out pulses once, 8*41 cycles after LOAD entry
REQ-027 Bit pattern, register 0 = 0xA5, CLKS_PER_BIT=4:
- stimulus: start_in pulse
- response: tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles
REQ-028 Start while busy:
- stimulus: start_in held high through the entire dump
- response: exactly one dump; one done_out pulse; IDLE entered the cycle after DONE, with a second dump accepted only at the next IDLE edge
REQ-029 Write during frame:
- stimulus: register 3 changed 0x44->0x99 during frame 2, and register 3 changed 0x99->0x11 during frame 3
- response: frame 3 carries 0x99
REQ-030 Reset mid-dump:
- stimulus: reset_in pulsed during DATA of frame 5
- response: tx_out=1 and busy_out=0 immediately; no done_out; sr_addr_out=0; the next start_in restarts at register 0
